cache_arbiter: RTL and testbench

Shares the single-port 1024x16 cache between the instruction-fetch port (read-only) and the data port (read/write), and sequences a full-cache flush on request. Sits between the fetch/memory stages and the cache; it is the only block that drives the cache's address, Wr, Rd and data inputs. Cache reads are combinational and writes land on the clock edge; the arbiter registers every cache-side control so that no requester input reaches the cache combinationally.

---
 rtl/cache_arb_pkg.sv | 16 +
 rtl/cache_arb_pick.sv | 28 ++
 rtl/cache_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache arbiter: FSM states, port IDs and bus widths.
package cache_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Combinational winner select between the eligible fetch and data requests.
// CACHE_ARB_RR_EN: ties go to the port not granted last; otherwise the data port always wins ties.
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic elig_i,
  input  logic elig_d,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_port
);

`ifndef CACHE_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_vld  = elig_i | elig_d;
    grant_port = elig_d ? PORT_D : PORT_I;
`ifdef CACHE_ARB_RR_EN
    if (elig_i && elig_d) begin
      grant_port = ~last_grant;
    end
`endif
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single-port cache between fetch and data ports (Req->Ack 2 cycles, one access per 2 cycles) and sweeps zeros on Flush.
// Tie-break policy is chosen in cache_arb_pick by CACHE_ARB_RR_EN; Flush always preempts both ports. Assumes AW < 16.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          Clock_Puls,
  input  logic          Reset,
  input  logic          I_Req,
  input  logic [15:0]   I_Adr,
  output logic          I_Ack,
  output logic [DW-1:0] I_D_o,
  input  logic          D_Req,
  input  logic          D_Wr,
  input  logic [15:0]   D_Adr,
  input  logic [DW-1:0] D_D_i,
  output logic          D_Ack,
  output logic [DW-1:0] D_D_o,
  input  logic          Flush,
  output logic          Busy,
  output logic [15:0]   C_Adr,
  output logic          C_Wr,
  output logic          C_Rd,
  output logic [DW-1:0] C_D_i,
  input  logic [DW-1:0] C_D_o
);

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            port_q, port_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [DW-1:0]   i_dat_q, i_dat_d;
  logic [DW-1:0]   d_dat_q, d_dat_d;

  logic            grant_vld, grant_port;
  logic            flush_req;
  logic            unused_adr_hi;

  assign unused_adr_hi = ^{I_Adr[15:AW], D_Adr[15:AW]};
  assign flush_req     = pend_q | Flush;

  // A port is ignored in its own Ack cycle so a held Req is not re-granted back to back.
  cache_arb_pick u_pick (
    .elig_i     (I_Req & ~i_ack_q),
    .elig_d     (D_Req & ~d_ack_q),
    .last_grant (last_q),
    .grant_vld  (grant_vld),
    .grant_port (grant_port)
  );

  always_ff @(posedge Clock_Puls or posedge Reset) begin
    if (Reset) begin
      state_q <= ARB;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= PORT_I;
      port_q  <= PORT_I;
      adr_q   <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_dat_q <= '0;
      d_dat_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      adr_q   <= adr_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      i_dat_q <= i_dat_d;
      d_dat_q <= d_dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (flush_req)      state_d = FLUSH;
        else if (grant_vld) state_d = ACC;
      end
      ACC:     state_d = ARB;
      FLUSH:   if (&cnt_q) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    pend_d  = flush_req;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    adr_d   = adr_q;
    wr_d    = wr_q;
    wdat_d  = wdat_q;
    i_ack_d = 1'b0;
    d_ack_d = 1'b0;
    i_dat_d = i_dat_q;
    d_dat_d = d_dat_q;
    case (state_q)
      ARB: begin
        if (!flush_req && grant_vld) begin
          port_d = grant_port;
          last_d = grant_port;
          adr_d  = (grant_port == PORT_D) ? D_Adr[AW-1:0] : I_Adr[AW-1:0];
          wr_d   = (grant_port == PORT_D) & D_Wr;
          wdat_d = D_D_i;
        end
      end
      ACC: begin
        if (port_q == PORT_D) begin
          d_ack_d = 1'b1;
          if (!wr_q) d_dat_d = C_D_o;
        end else begin
          i_ack_d = 1'b1;
          i_dat_d = C_D_o;
        end
      end
      FLUSH: begin
        // Pulses arriving mid-sweep are absorbed: pending drops when the last entry is written.
        cnt_d = cnt_q + AW'(1);
        if (&cnt_q) begin
          pend_d = 1'b0;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    C_Adr = '0;
    C_Wr  = 1'b0;
    C_Rd  = 1'b0;
    C_D_i = '0;
    case (state_q)
      ACC: begin
        C_Adr = 16'(adr_q);
        C_Wr  = wr_q;
        C_Rd  = ~wr_q;
        C_D_i = wr_q ? wdat_q : '0;
      end
      FLUSH: begin
        C_Adr = 16'(cnt_q);
        C_Wr  = 1'b1;
      end
      default: ;
    endcase
    Busy  = pend_q | (state_q == FLUSH);
    I_Ack = i_ack_q;
    D_Ack = d_ack_q;
    I_D_o = i_dat_q;
    D_D_o = d_dat_q;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cache_arbiter;

  localparam int DEPTH = 1024;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        I_Req, I_Ack, D_Req, D_Wr, D_Ack, Flush, Busy, C_Wr, C_Rd;
  logic [15:0] I_Adr, D_Adr, D_D_i, I_D_o, D_D_o, C_Adr, C_D_i, C_D_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment cache: combinational read, write on the rising edge.
  logic [15:0] cache_mem [DEPTH];
  logic [15:0] ref_mem   [DEPTH];
  assign C_D_o = cache_mem[C_Adr[9:0]];
  always @(posedge clk) if (C_Wr) cache_mem[C_Adr[9:0]] <= C_D_i;

  cache_arbiter dut (
    .Clock_Puls (clk),
    .Reset      (rst),
    .I_Req      (I_Req),
    .I_Adr      (I_Adr),
    .I_Ack      (I_Ack),
    .I_D_o      (I_D_o),
    .D_Req      (D_Req),
    .D_Wr       (D_Wr),
    .D_Adr      (D_Adr),
    .D_D_i      (D_D_i),
    .D_Ack      (D_Ack),
    .D_D_o      (D_D_o),
    .Flush      (Flush),
    .Busy       (Busy),
    .C_Adr      (C_Adr),
    .C_Wr       (C_Wr),
    .C_Rd       (C_Rd),
    .C_D_i      (C_D_i),
    .C_D_o      (C_D_o)
  );

  // Returns 1 when the data port should win, from the eligible requests and who was granted last.
  function automatic bit pick_data(bit ei, bit ed, bit last_was_d);
    if (ei && ed) return RR ? !last_was_d : 1'b1;
    return ed;
  endfunction

  task automatic test_reset();
    rst = 1'b1; I_Req = 0; I_Adr = 0; D_Req = 0; D_Wr = 0; D_Adr = 0; D_D_i = 0; Flush = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({I_Ack, D_Ack, Busy, C_Wr, C_Rd} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 00000", {I_Ack, D_Ack, Busy, C_Wr, C_Rd});
    end
    n_cmp++;
    if ({I_D_o, D_D_o, C_Adr, C_D_i} !== 64'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {I_D_o, D_D_o, C_Adr, C_D_i});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({I_Ack, D_Ack, Busy, C_Wr, C_Rd} !== 5'b0) begin
      n_bad++; $display("FAIL reset_release: got %b want 00000", {I_Ack, D_Ack, Busy, C_Wr, C_Rd});
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({C_Wr, C_Rd, I_Ack, D_Ack} !== 4'b0 || C_Adr !== 16'h0 || C_D_i !== 16'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
  endtask

  task automatic test_fetch_read();
    cache_mem[5] <= 16'h1234;
    I_Req = 1'b1; I_Adr = 16'h0005;
    @(negedge clk);
    n_cmp++;
    if ({C_Rd, C_Wr, C_Adr} !== {1'b1, 1'b0, 16'h0005}) begin
      n_bad++; $display("FAIL fetch_acc: got rd=%b wr=%b adr=%h want rd=1 wr=0 adr=0005", C_Rd, C_Wr, C_Adr);
    end
    n_cmp++;
    if (I_Ack !== 1'b0) begin n_bad++; $display("FAIL fetch_early_ack: got %b want 0", I_Ack); end
    @(negedge clk);
    n_cmp++;
    if ({I_Ack, I_D_o} !== {1'b1, 16'h1234}) begin
      n_bad++; $display("FAIL fetch_ack: got ack=%b dat=%h want ack=1 dat=1234", I_Ack, I_D_o);
    end
    I_Req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({I_Ack, I_D_o} !== {1'b0, 16'h1234}) begin
      n_bad++; $display("FAIL fetch_hold: got ack=%b dat=%h want ack=0 dat=1234", I_Ack, I_D_o);
    end
  endtask

  task automatic test_data_write_read();
    D_Req = 1'b1; D_Wr = 1'b1; D_Adr = 16'h07FF; D_D_i = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if ({C_Wr, C_Rd, C_Adr, C_D_i} !== {1'b1, 1'b0, 16'h03FF, 16'hBEEF}) begin
      n_bad++; $display("FAIL dwrite_acc: got wr=%b rd=%b adr=%h di=%h want 1 0 03ff beef", C_Wr, C_Rd, C_Adr, C_D_i);
    end
    @(negedge clk);
    n_cmp++;
    if ({D_Ack, D_D_o} !== {1'b1, 16'h0000}) begin
      n_bad++; $display("FAIL dwrite_ack: got ack=%b dat=%h want ack=1 dat=0000", D_Ack, D_D_o);
    end
    D_Req = 1'b0;
    @(negedge clk);
    D_Req = 1'b1; D_Wr = 1'b0; D_Adr = 16'h03FF;
    @(negedge clk);
    n_cmp++;
    if ({C_Rd, C_Wr, C_Adr} !== {1'b1, 1'b0, 16'h03FF}) begin
      n_bad++; $display("FAIL dread_acc: got rd=%b wr=%b adr=%h want 1 0 03ff", C_Rd, C_Wr, C_Adr);
    end
    @(negedge clk);
    n_cmp++;
    if ({D_Ack, D_D_o} !== {1'b1, 16'hBEEF}) begin
      n_bad++; $display("FAIL dread_ack: got ack=%b dat=%h want ack=1 dat=beef", D_Ack, D_D_o);
    end
    D_Req = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters re-raise Req right after each Ack; the port just acked is ineligible, so grants alternate.
  task automatic test_tie();
    bit got_d [8];
    bit first_d;
    int n = 0;
    first_d = pick_data(1'b1, 1'b1, 1'b1);  // last grant before this test was the data port
    I_Adr = 16'($urandom); D_Adr = 16'($urandom); D_Wr = 1'b0;
    I_Req = 1'b1; D_Req = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (I_Ack) begin if (n < 8) got_d[n] = 1'b0; n++; I_Req = 1'b0; end
      else if (n < 8) I_Req = 1'b1;
      if (D_Ack) begin if (n < 8) got_d[n] = 1'b1; n++; D_Req = 1'b0; end
      else if (n < 8) D_Req = 1'b1;
      if (n >= 8 && !I_Req && !D_Req) break;
    end
    n_cmp++;
    if (n < 8) begin n_bad++; $display("FAIL tie_count: got %0d grants want 8", n); end
    for (int k = 0; k < 8 && k < n; k++) begin
      n_cmp++;
      if (got_d[k] !== (first_d ^ k[0])) begin
        n_bad++; $display("FAIL tie_grant%0d: got %s want %s", k, got_d[k] ? "D" : "I", (first_d ^ k[0]) ? "D" : "I");
      end
    end
    I_Req = 1'b0; D_Req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rr_tie();
    bit ok = 0;
    bit exp_d;
    D_Req = 1'b1; D_Wr = 1'b0; D_Adr = 16'h0022;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (D_Ack) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rr_setup: got no D_Ack want D_Ack within 10 cycles"); end
    D_Req = 1'b0;
    @(negedge clk);
    I_Req = 1'b1; I_Adr = 16'h0011; D_Req = 1'b1;
    exp_d = pick_data(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (C_Adr !== (exp_d ? 16'h0022 : 16'h0011)) begin
      n_bad++; $display("FAIL rr_winner_adr: got %h want %h", C_Adr, exp_d ? 16'h0022 : 16'h0011);
    end
    @(negedge clk);
    n_cmp++;
    if ({I_Ack, D_Ack} !== (exp_d ? 2'b01 : 2'b10)) begin
      n_bad++; $display("FAIL rr_winner_ack: got %b want %b", {I_Ack, D_Ack}, exp_d ? 2'b01 : 2'b10);
    end
    if (exp_d) D_Req = 1'b0; else I_Req = 1'b0;
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (I_Ack || D_Ack) begin ok = 1; I_Req = 1'b0; D_Req = 1'b0; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rr_loser_served: got no Ack want Ack within 10 cycles"); end
    I_Req = 1'b0; D_Req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_during_acc();
    int bad = 0;
    D_Req = 1'b1; D_Wr = 1'b1; D_Adr = 16'h0040; D_D_i = 16'h5A5A;
    @(negedge clk);
    n_cmp++;
    if (C_Wr !== 1'b1) begin n_bad++; $display("FAIL fda_acc: got C_Wr=%b want 1", C_Wr); end
    Flush = 1'b1; I_Req = 1'b1; I_Adr = 16'h0040;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++;
    if ({D_Ack, Busy, C_Wr, C_Rd} !== 4'b1100) begin
      n_bad++; $display("FAIL fda_ack: got ack/busy/wr/rd=%b want 1100", {D_Ack, Busy, C_Wr, C_Rd});
    end
    D_Req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      if (C_Wr !== 1'b1 || C_Rd !== 1'b0 || C_Adr !== 16'(k) || C_D_i !== 16'h0 || Busy !== 1'b1 || I_Ack !== 1'b0) bad++;
      Flush = (k == 512);
    end
    Flush = 1'b0;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL fda_sweep: got %0d bad sweep cycles want 0", bad); end
    @(negedge clk);
    n_cmp++;
    if ({Busy, C_Wr, C_Rd} !== 3'b000) begin
      n_bad++; $display("FAIL fda_after: got busy/wr/rd=%b want 000", {Busy, C_Wr, C_Rd});
    end
    @(negedge clk);
    n_cmp++;
    if ({C_Rd, C_Adr} !== {1'b1, 16'h0040}) begin
      n_bad++; $display("FAIL fda_pending_acc: got rd=%b adr=%h want rd=1 adr=0040", C_Rd, C_Adr);
    end
    @(negedge clk);
    n_cmp++;
    if ({I_Ack, I_D_o} !== {1'b1, 16'h0000}) begin
      n_bad++; $display("FAIL fda_pending_ack: got ack=%b dat=%h want ack=1 dat=0000", I_Ack, I_D_o);
    end
    I_Req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({Busy, C_Wr} !== 2'b00) begin
      n_bad++; $display("FAIL fda_no_resweep: got busy/wr=%b want 00", {Busy, C_Wr});
    end
  endtask

  task automatic test_reset_mid_flush();
    bit found = 0;
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (C_Wr === 1'b1 && C_Adr === 16'd300) begin found = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL rmf_reach300: got C_Adr=%h want 012c within 400 cycles", C_Adr); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({I_Ack, D_Ack, Busy, C_Wr, C_Rd, C_Adr, C_D_i, I_D_o, D_D_o} !== 69'h0) begin
      n_bad++; $display("FAIL rmf_zero: got %h want 0", {I_Ack, D_Ack, Busy, C_Wr, C_Rd, C_Adr, C_D_i, I_D_o, D_D_o});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({Busy, C_Wr} !== 2'b00) begin n_bad++; $display("FAIL rmf_idle: got busy/wr=%b want 00", {Busy, C_Wr}); end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_cmp++;
    if ({Busy, C_Wr, C_Adr} !== {2'b11, 16'h0000}) begin
      n_bad++; $display("FAIL rmf_restart0: got busy=%b wr=%b adr=%h want 1 1 0000", Busy, C_Wr, C_Adr);
    end
    @(negedge clk);
    n_cmp++;
    if (C_Adr !== 16'h0001) begin n_bad++; $display("FAIL rmf_restart1: got adr=%h want 0001", C_Adr); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model: one access or one sweep step per cycle.
  task automatic test_random();
    bit          m_acc, m_acc_d, m_wr, m_pend, m_last_d;
    int          m_adr, m_sweep;
    logic [15:0] m_dat;
    bit          e_iack, e_dack, n_iack, n_dack, e_busy, ei, ed;
    logic [15:0] e_ido, e_ddo, e_cadr, e_cdi, obs_cdi;
    bit          e_cwr, e_crd;
    logic [68:0] exp_v, obs_v;
    logic [15:0] v;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = 16'($urandom);
      cache_mem[i] <= v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    rst = 1'b0; I_Req = 0; D_Req = 0; Flush = 0;
    m_acc = 0; m_acc_d = 0; m_wr = 0; m_pend = 0; m_last_d = 0; m_adr = 0; m_sweep = -1; m_dat = 0;
    e_iack = 0; e_dack = 0; e_ido = 0; e_ddo = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      e_cadr = 0; e_cwr = 0; e_crd = 0; e_cdi = 0;
      if (m_acc) begin
        e_cadr = 16'(m_adr); e_cwr = m_wr; e_crd = !m_wr; e_cdi = m_wr ? m_dat : 16'h0;
      end else if (m_sweep >= 0) begin
        e_cadr = 16'(m_sweep); e_cwr = 1'b1;
      end
      e_busy  = m_pend || (m_sweep >= 0);
      obs_cdi = (m_acc && !m_wr) ? 16'h0 : C_D_i;
      exp_v = {e_cadr, e_cwr, e_crd, e_cdi, e_iack, e_dack, e_ido, e_ddo, e_busy};
      obs_v = {C_Adr, C_Wr, C_Rd, obs_cdi, I_Ack, D_Ack, I_D_o, D_D_o, Busy};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rand_cyc%0d: got adr/wr/rd/di/iack/dack/ido/ddo/busy=%h want %h", cyc, obs_v, exp_v);
      end
      if (e_iack) I_Req = 1'b0;
      else if (!I_Req && $urandom_range(0, 2) == 0) begin
        I_Req = 1'b1; I_Adr = {6'($urandom), 10'($urandom_range(0, 15))};
      end
      if (e_dack) D_Req = 1'b0;
      else if (!D_Req && $urandom_range(0, 2) == 0) begin
        D_Req = 1'b1; D_Wr = 1'($urandom); D_D_i = 16'($urandom);
        D_Adr = {6'($urandom), 10'($urandom_range(0, 15))};
      end
      Flush = ($urandom_range(0, 399) == 0);
      ei = I_Req && !e_iack;
      ed = D_Req && !e_dack;
      n_iack = 0; n_dack = 0;
      if (m_acc) begin
        if (m_wr) ref_mem[m_adr] = m_dat;
        else if (m_acc_d) e_ddo = ref_mem[m_adr];
        else e_ido = ref_mem[m_adr];
        if (m_acc_d) n_dack = 1; else n_iack = 1;
        m_acc = 0;
        if (Flush) m_pend = 1;
      end else if (m_sweep >= 0) begin
        ref_mem[m_sweep] = 16'h0;
        if (m_sweep == DEPTH - 1) begin m_sweep = -1; m_pend = 0; end
        else m_sweep++;
      end else if (m_pend || Flush) begin
        m_sweep = 0; m_pend = 1;
      end else if (ei || ed) begin
        m_acc_d  = pick_data(ei, ed, m_last_d);
        m_last_d = m_acc_d;
        m_acc    = 1;
        m_adr    = int'(m_acc_d ? D_Adr : I_Adr) % DEPTH;
        m_wr     = m_acc_d && D_Wr;
        m_dat    = D_D_i;
      end
      e_iack = n_iack; e_dack = n_dack;
    end
    I_Req = 0; D_Req = 0; Flush = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) cache_mem[i] <= 16'($urandom);
    test_reset();
    test_idle();
    test_fetch_read();
    test_data_write_read();
    test_tie();
    test_rr_tie();
    test_flush_during_acc();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
